// File: rtl/irq_pkg.sv
// Shared widths and FSM state encoding for the interrupt pending controller.
package irq_pkg;

    localparam int unsigned NUM_IRQ = 4;
    localparam int unsigned ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/priority_encoder.sv
// Fixed-priority encoder: out is the highest set index of in, v flags any set bit.
module priority_encoder
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] in,
    output logic [ID_W-1:0]    out,
    output logic               v
);

    // Ascending scan so the highest set index is the last one written.
    always_comb begin
        out = '0;
        v   = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (in[i]) begin
                out = ID_W'(i);
                v   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge-triggered interrupt pending register with mask, priority grant and REQ/SERVICE handshake.
// Build option: IRQ_SYNC_EN inserts a two-flop synchronizer on irq_in ahead of edge detect.
module irq_pending_ctrl
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               ack,
    input  logic               eoi,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_hist;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] pending_n;
    logic [ID_W-1:0]    win_id;
    logic               win_v;
    logic [ID_W-1:0]    irq_id_n;
    irq_state_e         state;
    irq_state_e         state_n;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = irq_in;
`endif

    assign rise     = irq_s & ~irq_hist;
    assign eligible = pending & ~mask;

    priority_encoder u_prio (
        .in  (eligible),
        .out (win_id),
        .v   (win_v)
    );

    // Next state, grant latch and ack-driven clear.
    always_comb begin
        state_n  = state;
        irq_id_n = irq_id;
        clr      = '0;
        case (state)
            IDLE: begin
                if (win_v) begin
                    state_n  = REQ;
                    irq_id_n = win_id;
                end
            end
            REQ: begin
                if (ack) begin
                    state_n = SERVICE;
                    clr     = NUM_IRQ'(1) << irq_id;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A fresh edge overrides a same-cycle ack clear.
    assign pending_n = (pending & ~clr) | rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            irq_id   <= '0;
            pending  <= '0;
            mask     <= '0;
            irq_hist <= '0;
        end else begin
            state    <= state_n;
            irq_id   <= irq_id_n;
            pending  <= pending_n;
            irq_hist <= irq_s;
            if (mask_wr) begin
                mask <= mask_in;
            end
        end
    end

    assign irq_req = (state == REQ);

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl: directed scenarios plus random traffic vs a reference model.
// Honours IRQ_SYNC_EN the same way as the design (two extra sample delays on irq_in).
module tb_irq_pending_ctrl;
    import irq_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_wr;
    logic [3:0] mask_in;
    logic       ack;
    logic       eoi;
    logic       irq_req;
    logic [1:0] irq_id;
    logic [3:0] pending;

    always #5 clk = ~clk;

    irq_pending_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .mask_wr (mask_wr),
        .mask_in (mask_in),
        .ack     (ack),
        .eoi     (eoi),
        .irq_req (irq_req),
        .irq_id  (irq_id),
        .pending (pending)
    );

    typedef struct packed {
        logic       req;
        logic [1:0] id;
        logic [3:0] pend;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Reference model: pending set of requests, a mask, and a grant phase
    // (0 = nothing granted, 1 = waiting for ack, 2 = in service).
    bit [3:0] m_pend, m_mask, m_last, m_s1, m_s2;
    int       m_phase, m_id;

    task automatic model_step();
        bit [3:0] samp, new_e, elig;
        if (rst) begin
            m_pend = 0; m_mask = 0; m_last = 0; m_s1 = 0; m_s2 = 0;
            m_phase = 0; m_id = 0;
            return;
        end
        samp = (SD == 2) ? m_s2 : irq_in;
        m_s2 = m_s1;
        m_s1 = irq_in;
        new_e  = samp & ~m_last;
        m_last = samp;
        elig   = m_pend & ~m_mask;
        case (m_phase)
            0: if (elig != 0) begin
                for (int i = 0; i < 4; i++) if (elig[i]) m_id = i;
                m_phase = 1;
            end
            1: if (ack) begin
                m_pend[m_id] = 1'b0;
                m_phase = 2;
            end
            default: if (eoi) m_phase = 0;
        endcase
        m_pend = m_pend | new_e;
        if (mask_wr) m_mask = mask_in;
    endtask

    function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h (req,id,pending)", name, cyc, act, exp);
        end
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        e.req  = (m_phase == 1);
        e.id   = 2'(m_id);
        e.pend = m_pend;
        sb_q.push_back(e);
        cyc++;
        #1;
    endtask

    task automatic chk_out(string name, logic r, logic [1:0] id, logic [3:0] p);
        chk(name, {1'b0, irq_req, irq_id, pending}, {1'b0, r, id, p});
    endtask

    task automatic settle();
        irq_in = 4'b0000; ack = 1'b0; eoi = 1'b0; mask_wr = 1'b0;
        repeat (SD + 2) tick();
    endtask

    // Monitor: compares DUT outputs against queued model expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("scoreboard", {1'b0, irq_req, irq_id, pending}, {1'b0, e});
            end
        end
    end

    initial begin
        rst = 1'b1; irq_in = 4'b0000; mask_wr = 1'b0; mask_in = 4'b0000; ack = 1'b0; eoi = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 2'b00, 4'b0000);
        rst = 1'b0;
        tick();

        // Single edge: latency of pending and grant.
        irq_in = 4'b0100;
        repeat (SD) begin
            tick();
            chk_out("r28_sync_gap", 1'b0, 2'b00, 4'b0000);
        end
        tick();
        chk_out("r28_pending", 1'b0, 2'b00, 4'b0100);
        tick();
        chk_out("r28_grant", 1'b1, 2'b10, 4'b0100);
        ack = 1'b1; tick(); ack = 1'b0;
        chk_out("r28_ack", 1'b0, 2'b10, 4'b0000);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk_out("r28_eoi", 1'b0, 2'b10, 4'b0000);
        settle();

        // Two simultaneous edges, eoi-in-REQ ignored, ack+eoi together.
        irq_in = 4'b0011;
        repeat (SD + 1) tick();
        chk_out("r29_pending", 1'b0, 2'b10, 4'b0011);
        tick();
        chk_out("r29_grant1", 1'b1, 2'b01, 4'b0011);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk_out("r29_eoi_in_req", 1'b1, 2'b01, 4'b0011);
        ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
        chk_out("r29_ack_eoi", 1'b0, 2'b01, 4'b0001);
        tick();
        chk_out("r29_hold_service", 1'b0, 2'b01, 4'b0001);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk_out("r29_eoi", 1'b0, 2'b01, 4'b0001);
        tick();
        chk_out("r29_grant2", 1'b1, 2'b00, 4'b0001);
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk_out("r29_done", 1'b0, 2'b00, 4'b0000);
        settle();

        // Masked request is retained, granted once unmasked.
        mask_wr = 1'b1; mask_in = 4'b1000; tick(); mask_wr = 1'b0;
        irq_in = 4'b1000;
        repeat (SD + 1) tick();
        chk_out("r30_masked_pend", 1'b0, 2'b00, 4'b1000);
        ack = 1'b1; tick(); ack = 1'b0;
        chk_out("r30_ack_idle", 1'b0, 2'b00, 4'b1000);
        mask_wr = 1'b1; mask_in = 4'b0000; tick(); mask_wr = 1'b0;
        chk_out("r30_unmask_edge", 1'b0, 2'b00, 4'b1000);
        tick();
        chk_out("r30_grant", 1'b1, 2'b11, 4'b1000);
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk_out("r30_done", 1'b0, 2'b11, 4'b0000);
        settle();

        // New edge coincident with ack: set wins, re-granted after eoi.
        irq_in = 4'b0100;
        repeat (SD + 2) tick();
        chk_out("r31_grant", 1'b1, 2'b10, 4'b0100);
        irq_in = 4'b0000; tick();
        irq_in = 4'b0100;
        repeat (SD) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk_out("r31_set_wins", 1'b0, 2'b10, 4'b0100);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk_out("r31_regrant", 1'b1, 2'b10, 4'b0100);
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        settle();

        // Reset while in SERVICE with pending=1010.
        irq_in = 4'b0001;
        repeat (SD + 2) tick();
        chk_out("r32_grant", 1'b1, 2'b00, 4'b0001);
        irq_in = 4'b1011;
        repeat (SD + 1) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk_out("r32_service", 1'b0, 2'b00, 4'b1010);
        rst = 1'b1; tick();
        chk_out("r32_reset", 1'b0, 2'b00, 4'b0000);
        repeat (3) begin
            tick();
            chk_out("r32_held_high", 1'b0, 2'b00, 4'b0000);
        end
        irq_in = 4'b0000;
        repeat (SD + 1) tick();
        rst = 1'b0; tick();
        chk_out("r32_release", 1'b0, 2'b00, 4'b0000);

        // Random traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom);
            mask_wr = ($urandom_range(0, 15) == 0);
            mask_in = 4'($urandom);
            ack     = ($urandom_range(0, 2) == 0);
            eoi     = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; ack = 1'b0; eoi = 1'b0; mask_wr = 1'b0;
        tick();

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The module SHALL have port irq_in, input, 4 bits: raw interrupt request lines; bit 3 has the highest priority.
REQ-004 The module SHALL have port mask_wr, input, 1 bit: when high, mask_in is loaded into the mask register.
REQ-005 The module SHALL have port mask_in, input, 4 bits: new mask value; 1 = masked.
REQ-006 The module SHALL have port ack, input, 1 bit: one-cycle acknowledge from the consumer.
REQ-007 The module SHALL have port eoi, input, 1 bit: one-cycle end-of-interrupt from the consumer.
REQ-008 The module SHALL have port irq_req, output, 1 bit: interrupt request to the consumer.
REQ-009 The module SHALL have port irq_id, output, 2 bits: index of the granted request.
REQ-010 The module SHALL have port pending, output, 4 bits: pending register contents.

Function
REQ-011 Edge detect SHALL set pending[i] at the clock edge where irq_in[i] is sampled high and was sampled low on the previous edge; a held level SHALL NOT re-set the bit.
REQ-012 Priority resolve SHALL pick the highest set index of (pending & ~mask); valid = that vector is nonzero.
REQ-013 FSM state IDLE SHALL go to REQ on the edge where valid is high, latching the resolved index into irq_id.
REQ-014 FSM state REQ SHALL drive irq_req=1 and hold irq_id stable; on ack it SHALL clear pending[irq_id] and go to SERVICE.
REQ-015 FSM state SERVICE SHALL drive irq_req=0, keep irq_id, and go to IDLE on eoi; there SHALL be no nesting or pre-emption.
REQ-016 irq_req SHALL be a decode of the state register (state==REQ) only.
REQ-017 Latency: an edge sampled at clock k from IDLE with mask clear SHALL give pending high after edge k and irq_req high after edge k+1.
REQ-018 ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-019 If ack and eoi arrive together in REQ, only ack SHALL take effect.
REQ-020 If a new edge sets pending[i] in the same cycle that ack clears it, set SHALL win.
REQ-021 A mask write during REQ or SERVICE SHALL NOT change the latched irq_id; masked pending bits SHALL be retained and become eligible when unmasked.
REQ-022 The mask write SHALL take effect for priority resolution from the edge after mask_wr.

Reset
REQ-023 While rst is high at a clock edge, the module SHALL set pending=0, mask=4'b0000, the edge-detect history=0, state=IDLE, irq_req=0 and irq_id=2'b00; reset mid-operation SHALL abandon any REQ/SERVICE with no ack required.

Configuration
REQ-024 With IRQ_SYNC_EN defined, irq_in SHALL pass through a two-flop synchronizer (reset to 0) before edge detect, adding exactly 2 cycles to REQ-017 latency.
REQ-025 Without IRQ_SYNC_EN, irq_in SHALL feed edge detect directly.

Structure
REQ-026 A shared package irq_pkg SHALL hold NUM_IRQ=4, ID_W=2 and the state enum {IDLE, REQ, SERVICE}.
REQ-027 The priority resolve SHALL be the codebase's existing priority_encoder sub-module (4-to-2, outputs out and v), instantiated once.

Verification
REQ-028 The bench SHALL check: reset, then irq_in=4'b0100 at cycle 2 -> pending=4'b0100 after the next edge; irq_req=1, irq_id=2'b10 one cycle later.
REQ-029 The bench SHALL check: irq_in 4'b0011 set simultaneously -> irq_id=2'b01; after ack, pending=4'b0001; after eoi, second grant with irq_id=2'b00.
REQ-030 The bench SHALL check: mask=4'b1000, then an irq_in[3] edge -> pending=4'b1000 and irq_req stays 0; writing mask=0 -> irq_req=1, irq_id=2'b11.
REQ-031 The bench SHALL check: a new irq_in[2] edge in the same cycle as ack for id 2 -> pending[2] stays 1 and is re-granted after eoi.
REQ-032 The bench SHALL check: rst asserted in SERVICE with pending=4'b1010 -> all outputs and pending are 0 on the next edge, and irq_in held high does not re-trigger.
REQ-033 The bench SHALL check: with IRQ_SYNC_EN, the REQ-028 stimulus gives irq_req exactly 2 cycles later than without it.
